mig_app_master: RTL

//  Initiator for the MIG 7-series user (app) interface: the far end of the DDR3 controller port.

---
 rtl/mig_app_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mig_app_master.sv
`default_nettype none
// ============================================================================
//  Module   : mig_app_master
//  Purpose  : Block-request initiator for the MIG 7-series app interface.
//             Splits one write/read block into BL8 commands, streams write
//             beats into the write-data FIFO and returns read beats in order.
//  Revision : 1.0  initial release
// ============================================================================
module mig_app_master #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_calib_complete,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_beats,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                app_ref_req,
  output logic                app_zq_req
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic [LEN_W-1:0]   dcnt_q, dcnt_d;
  logic [LEN_W-1:0]   ccnt_q, ccnt_d;
  logic [LEN_W-1:0]   rcnt_q, rcnt_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  logic               data_left;
  logic               cmd_left;
  logic               beat_acc;
  logic               cmd_acc;

  // Each BL8 command covers 8 column addresses; the sum wraps at the top.
  assign app_addr     = addr_q + ADDR_W'({ccnt_q, 3'b000});
  assign app_wdf_data = wr_data;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign app_ref_req  = 1'b0;
  assign app_zq_req   = 1'b0;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_last      = rd_last_q;
  assign done         = (state_q == S_DONE);

  // Next-state, counter updates and handshake outputs for the block FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_d      = beats_q;
    dcnt_d       = dcnt_q;
    ccnt_d       = ccnt_q;
    rcnt_d       = rcnt_q;
    req_ready    = 1'b0;
    wr_ready     = 1'b0;
    app_wdf_wren = 1'b0;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    beat_acc     = 1'b0;
    cmd_acc      = 1'b0;
    data_left    = (dcnt_q < beats_q);
    cmd_left     = (ccnt_q < beats_q);

    // Read data is only forwarded while a read block is in flight.
    rd_valid_d   = (state_q == S_READ) && app_rd_data_valid;
    rd_data_d    = app_rd_data;
    rd_last_d    = rd_valid_d && (rcnt_q == beats_q - LEN_W'(1));
    if (rd_valid_d) begin
      rcnt_d = rcnt_q + LEN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        req_ready = init_calib_complete && !rst;
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          beats_d = req_beats;
          dcnt_d  = '0;
          ccnt_d  = '0;
          rcnt_d  = '0;
          state_d = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wr_ready     = app_wdf_rdy && data_left;
        app_wdf_wren = wr_valid && data_left;
        beat_acc     = wr_valid && wr_ready;
        // A command may go out only once its beat is in (or entering) the FIFO.
        app_en       = (ccnt_q < dcnt_q) || (cmd_left && beat_acc);
        cmd_acc      = app_en && app_rdy;
        if (beat_acc) begin
          dcnt_d = dcnt_q + LEN_W'(1);
        end
        if (cmd_acc) begin
          ccnt_d = ccnt_q + LEN_W'(1);
          if (ccnt_q + LEN_W'(1) == beats_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        app_en  = cmd_left;
        app_cmd = 3'b001;
        cmd_acc = app_en && app_rdy;
        if (cmd_acc) begin
          ccnt_d = ccnt_q + LEN_W'(1);
        end
        if (rd_valid_q && rd_last_q) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and the registered read-return stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      dcnt_q     <= '0;
      ccnt_q     <= '0;
      rcnt_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      dcnt_q     <= dcnt_d;
      ccnt_q     <= ccnt_d;
      rcnt_q     <= rcnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule
`default_nettype wire
